// File: rtl/olivia_mc_ctrl_pkg.sv
// Shared types for the Olivia multi-cycle sequencer: FSM states, instruction
// classes, opcode patterns and the alu_op / pc_src encodings.
package olivia_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_CBZ     = 3'd3,
    CL_CBNZ    = 3'd4,
    CL_B       = 3'd5,
    CL_ILLEGAL = 3'd6
  } op_class_t;

  // 11-bit opcodes live in ir[31:21], CB opcodes in ir[31:24], B in ir[31:26]
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASS  = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;

  function automatic logic is_mem_class(input op_class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/olivia_mc_ctrl_op_decode.sv
// Combinational instruction classifier on the opcode field; shared with the
// ALU control so both agree on what an instruction is.
module olivia_op_decode
  import olivia_pkg::*;
(
  input  logic [10:0] i_opcode,
  output op_class_t   o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    if (i_opcode == OPC_ADD || i_opcode == OPC_SUB ||
        i_opcode == OPC_AND || i_opcode == OPC_ORR) begin
      o_class = CL_RTYPE;
    end else if (i_opcode == OPC_LDUR) begin
      o_class = CL_LOAD;
    end else if (i_opcode == OPC_STUR) begin
      o_class = CL_STORE;
    end else if (i_opcode[10:3] == OPC_CBZ) begin
      o_class = CL_CBZ;
    end else if (i_opcode[10:3] == OPC_CBNZ) begin
      o_class = CL_CBNZ;
    end else if (i_opcode[10:5] == OPC_B) begin
      o_class = CL_B;
    end
  end

endmodule

// File: rtl/olivia_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory
// handshakes, branch PC redirect, retire counter and sticky timeout fault.
module olivia_mc_ctrl
  import olivia_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic             zero_flag,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             reg_write,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  // Handshake: a request stays high from the first request cycle until the
  // cycle its ack is seen; that cycle completes the transfer. Acks seen
  // while the matching request is low are ignored.

  state_t           r_state;
  op_class_t        r_class;
  logic             r_run;
  logic [31:0]      r_wait;
  logic [CNT_W-1:0] r_retired;

  op_class_t w_dec_class;
  op_class_t w_class;
  logic      w_timeout;
  logic      w_cb_taken;
  logic      w_unused_ir;

  olivia_op_decode u_op_decode (
    .i_opcode (ir[31:21]),
    .o_class  (w_dec_class)
  );

  assign w_unused_ir = ^ir[20:0];

  // The IR is only trusted from DECODE on; later states use the latched class
  assign w_class    = (r_state == ST_DECODE) ? w_dec_class : r_class;
  assign w_timeout  = (MEM_TIMEOUT != 0) && ((r_wait + 32'd1) >= MEM_TIMEOUT);
  assign w_cb_taken = ((w_class == CL_CBZ) && zero_flag) ||
                      ((w_class == CL_CBNZ) && !zero_flag);

  assign fault     = (r_state == ST_FAULT);
  assign retired   = r_retired;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_class   <= CL_ILLEGAL;
      r_run     <= 1'b0;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        case (r_state)
          ST_FETCH: begin
            if (imem_ack) begin
              r_state <= ST_DECODE;
            end else if (w_timeout) begin
              r_state <= ST_FAULT;
            end else begin
              r_wait <= r_wait + 32'd1;
            end
          end
          ST_DECODE: begin
            r_class <= w_dec_class;
            r_wait  <= '0;
            if (w_dec_class == CL_B) begin
              r_retired <= r_retired + CNT_W'(1);
              r_state   <= ST_FETCH;
            end else if (w_dec_class == CL_ILLEGAL) begin
              r_state <= ST_FETCH;
            end else begin
              r_state <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            r_wait <= '0;
            if (r_class == CL_RTYPE) begin
              r_state <= ST_WB;
            end else if (is_mem_class(r_class)) begin
              r_state <= ST_MEM;
            end else begin
              r_retired <= r_retired + CNT_W'(1);
              r_state   <= ST_FETCH;
            end
          end
          ST_MEM: begin
            if (dmem_ack) begin
              r_wait <= '0;
              if (r_class == CL_LOAD) begin
                r_state <= ST_WB;
              end else begin
                r_retired <= r_retired + CNT_W'(1);
                r_state   <= ST_FETCH;
              end
            end else if (w_timeout) begin
              r_state <= ST_FAULT;
            end else begin
              r_wait <= r_wait + 32'd1;
            end
          end
          ST_WB: begin
            r_retired <= r_retired + CNT_W'(1);
            r_wait    <= '0;
            r_state   <= ST_FETCH;
          end
          ST_FAULT: r_state <= ST_FAULT;
          default:  r_state <= ST_FAULT;
        endcase
      end
    end
  end

  // r_run is cleared asynchronously, so every strobe drops in the reset cycle
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    reg2loc   = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    if (r_run) begin
      if (r_state == ST_DECODE || r_state == ST_EXEC ||
          r_state == ST_MEM || r_state == ST_WB) begin
        case (w_class)
          CL_RTYPE: alu_op = ALU_RTYPE;
          CL_LOAD, CL_STORE: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
          end
          CL_CBZ, CL_CBNZ: begin
            reg2loc = 1'b1;
            alu_op  = ALU_PASS;
          end
          default: ;
        endcase
      end
      case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: begin
          if (w_class == CL_B) begin
            pc_write = 1'b1;
            pc_src   = PC_BRANCH;
          end else if (w_class == CL_ILLEGAL) begin
            illegal = 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_cb_taken) begin
            pc_write = 1'b1;
            pc_src   = PC_BRANCH;
          end
        end
        ST_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = (w_class == CL_LOAD);
          mem_write = (w_class == CL_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          mem2reg   = (w_class == CL_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_olivia_mc_ctrl.sv
// Bench for olivia_mc_ctrl: directed instructions, randomized instruction
// stream against a per-instruction timing model, mid-instruction reset, timeout.
module tb_olivia_mc_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      ir;
  logic             zero_flag;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg2loc;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             mem2reg;
  logic             reg_write;
  logic             illegal;
  logic             fault;
  logic [CNT_W-1:0] retired;
  logic [2:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  int exp_ret = 0;

  logic [10:0] rops [4] = '{11'b10001011000, 11'b11001011000,
                            11'b10001010000, 11'b10101010000};

  olivia_mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .zero_flag (zero_flag),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg2loc   (reg2loc),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem2reg   (mem2reg),
    .reg_write (reg_write),
    .illegal   (illegal),
    .fault     (fault),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 CBNZ, 5 B, 6 illegal
  function automatic int classify(input logic [31:0] v);
    logic [10:0] op;
    op = v[31:21];
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return 0;
    if (op == 11'b11111000010) return 1;
    if (op == 11'b11111000000) return 2;
    if (v[31:24] == 8'b10110100) return 3;
    if (v[31:24] == 8'b10110101) return 4;
    if (v[31:26] == 6'b000101) return 5;
    return 6;
  endfunction

  // Entered and left at the falling edge of the first fetch cycle of an instruction.
  task automatic run_instr(input logic [31:0] v, input logic zf, input int iw, input int dw);
    int cls, n, icnt, dcnt, exp_lat, exec_cyc;
    int irw_cnt, irw_cyc, rw_cnt, rw_cyc, pcs_cnt, pcb_cnt, pcb_cyc;
    int mr_cnt, mw_cnt, ill_cnt, multi;
    logic m2r, prev_req, done, taken;
    logic [3:0] ex_sig;
    cls = classify(v);
    taken = (cls == 5) || (cls == 3 && zf) || (cls == 4 && !zf);
    case (cls)
      0:       exp_lat = 4;
      1:       exp_lat = 5 + dw;
      2:       exp_lat = 4 + dw;
      3, 4:    exp_lat = 3;
      default: exp_lat = 2;
    endcase
    exp_lat += iw;
    exec_cyc = iw + 3;
    {n, icnt, dcnt, irw_cnt, irw_cyc, rw_cnt, rw_cyc} = '0;
    {pcs_cnt, pcb_cnt, pcb_cyc, mr_cnt, mw_cnt, ill_cnt, multi} = '0;
    m2r = 1'b0; ex_sig = '0; prev_req = 1'b1; done = 1'b0;
    ir = v;
    zero_flag = zf;
    while (!done && n < 48) begin
      n++;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      if (n > 1 && imem_req && !prev_req) begin
        done = 1'b1;
      end else begin
        prev_req = imem_req;
        if (imem_req) begin imem_ack = (icnt == iw); icnt++; end
        else imem_ack = ($urandom_range(0, 3) == 0);
        if (dmem_req) begin dmem_ack = (dcnt == dw); dcnt++; end
        else dmem_ack = ($urandom_range(0, 3) == 0);
        #1;
        if (ir_write) begin irw_cnt++; irw_cyc = n; end
        if (reg_write) begin rw_cnt++; rw_cyc = n; m2r = mem2reg; end
        if (pc_write && pc_src == 2'd0) pcs_cnt++;
        if (pc_write && pc_src == 2'd1) begin pcb_cnt++; pcb_cyc = n; end
        if (mem_read) mr_cnt++;
        if (mem_write) mw_cnt++;
        if (illegal) ill_cnt++;
        if (int'(pc_write) + int'(reg_write) + int'(mem_write) > 1) multi++;
        if (n == exec_cyc) ex_sig = {reg2loc, alu_src, alu_op};
        @(negedge clk);
      end
    end
    chk("instr_complete", 32'(done), 32'd1);
    chk("latency", n - 1, exp_lat);
    chk("ir_write_count", irw_cnt, 1);
    chk("ir_write_cycle", irw_cyc, iw + 1);
    chk("pc_seq_count", pcs_cnt, 1);
    chk("pc_branch_count", pcb_cnt, taken ? 1 : 0);
    if (taken) chk("pc_branch_cycle", pcb_cyc, (cls == 5) ? iw + 2 : iw + 3);
    chk("reg_write_count", rw_cnt, (cls == 0 || cls == 1) ? 1 : 0);
    if (cls == 0) chk("reg_write_cycle", rw_cyc, iw + 4);
    if (cls == 1) chk("reg_write_cycle", rw_cyc, iw + dw + 5);
    if (cls == 0 || cls == 1) chk("mem2reg", 32'(m2r), (cls == 1) ? 1 : 0);
    chk("mem_read_cycles", mr_cnt, (cls == 1) ? dw + 1 : 0);
    chk("mem_write_cycles", mw_cnt, (cls == 2) ? dw + 1 : 0);
    chk("illegal_pulses", ill_cnt, (cls == 6) ? 1 : 0);
    chk("write_strobe_overlap", multi, 0);
    if (cls == 0) chk("exec_ctrl_rtype", 32'(ex_sig), 32'b0010);
    if (cls == 1 || cls == 2) chk("exec_ctrl_mem", 32'(ex_sig), 32'b1100);
    if (cls == 3 || cls == 4) chk("exec_ctrl_cb", 32'(ex_sig), 32'b1001);
    if (cls != 6) exp_ret = (exp_ret + 1) % (1 << CNT_W);
    chk("retired", 32'(retired), exp_ret);
    chk("no_fault", 32'(fault), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int k, fc;
    logic seen;
    rst = 1'b1; ir = '0; zero_flag = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_imem_req", 32'(imem_req), 32'd0);
    chk("reset_strobes", 32'({dmem_req, ir_write, pc_write, reg_write, mem_write, mem_read, illegal}), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("imem_req_before_first_edge", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("imem_req_first_cycle", 32'(imem_req), 32'd1);
    #1;

    run_instr(32'h8B030041, 1'b0, 0, 0);   // ADD X1,X2,X3
    run_instr(32'hF8408041, 1'b0, 0, 3);   // LDUR, ack after 3 waits
    run_instr(32'hB4000041, 1'b1, 0, 0);   // CBZ taken
    run_instr(32'hB5000041, 1'b1, 0, 0);   // CBNZ not taken
    run_instr(32'h14000004, 1'b0, 0, 0);   // B
    run_instr(32'h00000000, 1'b0, 0, 0);   // illegal
    run_instr(32'hF8000041, 1'b0, TMO - 1, TMO - 1);  // acks on the limit cycle
    run_instr(32'hB5000041, 1'b0, 2, 0);   // CBNZ taken

    for (int i = 0; i < 60; i++) begin
      v = $urandom();
      k = $urandom_range(0, 7);
      case (k)
        0, 7: v[31:21] = rops[$urandom_range(0, 3)];
        1: v[31:21] = 11'b11111000010;
        2: v[31:21] = 11'b11111000000;
        3: v[31:24] = 8'b10110100;
        4: v[31:24] = 8'b10110101;
        5: v[31:26] = 6'b000101;
        default: ;
      endcase
      run_instr(v, 1'($urandom_range(0, 1)), $urandom_range(0, TMO - 1), $urandom_range(0, 4));
    end

    // Abort a STUR in its first MEM cycle
    ir = 32'hF8000041;
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stur_mem_write_before_reset", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset_strobes", 32'({imem_req, dmem_req, pc_write, reg_write, mem_write, mem_read}), 32'd0);
    chk("mid_reset_retired", 32'(retired), 32'd0);
    exp_ret = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // No imem_ack ever: fault must appear after TMO request cycles
    seen = 1'b0;
    fc = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      if (fault) begin
        seen = 1'b1;
        fc = c;
      end else begin
        @(negedge clk);
      end
    end
    chk("fault_seen", 32'(seen), 32'd1);
    chk("fault_cycle", fc, TMO + 1);
    for (int c = 0; c < 5; c++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("fault_sticky", 32'(fault), 32'd1);
      chk("fault_strobes", 32'({imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write, mem_read}), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("fault_cleared_by_reset", 32'(fault), 32'd0);
    chk("retired_after_reset", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("fetch_after_fault_reset", 32'(imem_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
